// File: rtl/cpu_alu_arbiter.sv
// cpu_alu_arbiter
// ----------------
// Shares one combinational CPU_ALU between two requesters:
//   port A - execute stage
//   port B - auxiliary unit (address / trap logic)
//
// Transaction flow:
//   IDLE     pick a requester, pulse its ready, register its op/operands
//            onto the ALU input pins
//   EXECUTE  one cycle while the ALU evaluates; capture its result into
//            the owner's response register
//   RESPOND  hold valid/result until the owner acknowledges
//
// The ALU operand registers only change on a grant edge, so the ALU sees
// stable inputs for the whole EXECUTE/RESPOND window.
module cpu_alu_arbiter #(
  // 1 = round-robin between A and B, 0 = fixed priority (A always wins)
  parameter bit P_ROUND_ROBIN = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,       // asynchronous, active-low

  // Requester A (execute stage)
  input  logic        i_a_request,
  input  logic [5:0]  i_a_op,
  input  logic [31:0] i_a_op1,
  input  logic [31:0] i_a_op2,
  output logic        o_a_ready,
  output logic        o_a_valid,
  output logic [31:0] o_a_result,
  input  logic        i_a_ack,

  // Requester B (auxiliary unit)
  input  logic        i_b_request,
  input  logic [5:0]  i_b_op,
  input  logic [31:0] i_b_op1,
  input  logic [31:0] i_b_op2,
  output logic        o_b_ready,
  output logic        o_b_valid,
  output logic [31:0] o_b_result,
  input  logic        i_b_ack,

  // Shared ALU
  output logic [5:0]  o_alu_op,
  output logic [31:0] o_alu_op1,
  output logic [31:0] o_alu_op2,
  input  logic [31:0] i_alu_result
);

  // ------------------------------------------------------------------
  // State encoding and requester identifiers
  // ------------------------------------------------------------------
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXECUTE = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  logic [1:0]  r_state;
  logic        r_owner;        // requester whose op is in flight
  logic        r_last_grant;   // requester granted most recently

  // ------------------------------------------------------------------
  // Combinational signals
  // ------------------------------------------------------------------
  logic [1:0]  w_state_next;
  logic        w_grant;        // a grant happens this cycle
  logic        w_grant_sel;    // which requester is granted
  logic        w_owner_ack;    // acknowledge from the current owner only
  logic [5:0]  w_sel_op;
  logic [31:0] w_sel_op1;
  logic [31:0] w_sel_op2;

  // Arbitration: only in IDLE; a tie goes to the side not granted last
  // in round-robin mode, or to A in fixed-priority mode.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_sel = OWNER_A;
    if (r_state == S_IDLE) begin
      unique case ({i_a_request, i_b_request})
        2'b10: begin
          w_grant     = 1'b1;
          w_grant_sel = OWNER_A;
        end
        2'b01: begin
          w_grant     = 1'b1;
          w_grant_sel = OWNER_B;
        end
        2'b11: begin
          w_grant     = 1'b1;
          w_grant_sel = (P_ROUND_ROBIN && (r_last_grant == OWNER_A))
                        ? OWNER_B : OWNER_A;
        end
        default: begin
          w_grant     = 1'b0;
          w_grant_sel = OWNER_A;
        end
      endcase
    end
  end

  // Ready is a same-cycle accept pulse; at most one side is ever granted.
  assign o_a_ready = w_grant && (w_grant_sel == OWNER_A);
  assign o_b_ready = w_grant && (w_grant_sel == OWNER_B);

  // Only the owner's acknowledge retires a result; the other side's is ignored.
  assign w_owner_ack = (r_owner == OWNER_A) ? i_a_ack : i_b_ack;

  // Operand mux feeding the ALU input registers.
  assign w_sel_op  = (w_grant_sel == OWNER_B) ? i_b_op  : i_a_op;
  assign w_sel_op1 = (w_grant_sel == OWNER_B) ? i_b_op1 : i_a_op1;
  assign w_sel_op2 = (w_grant_sel == OWNER_B) ? i_b_op2 : i_a_op2;

  // Next-state logic: IDLE -> EXECUTE on grant, EXECUTE lasts one cycle,
  // RESPOND waits for the owner's acknowledge.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_grant)     w_state_next = S_EXECUTE;
      S_EXECUTE:                  w_state_next = S_RESPOND;
      S_RESPOND: if (w_owner_ack) w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: clocked blocks use non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Owner and last-grant tracking; last grant resets to B so A wins the
  // first tie after reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_owner      <= OWNER_A;
      r_last_grant <= OWNER_B;
    end else if (w_grant) begin
      r_owner      <= w_grant_sel;
      r_last_grant <= w_grant_sel;
    end
  end

  // ALU operand registers: loaded only on a grant edge, hold otherwise.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_alu_op  <= '0;
      o_alu_op1 <= '0;
      o_alu_op2 <= '0;
    end else if (w_grant) begin
      o_alu_op  <= w_sel_op;
      o_alu_op1 <= w_sel_op1;
      o_alu_op2 <= w_sel_op2;
    end
  end

  // Result capture at the end of EXECUTE into the owner's register; the
  // value is kept after valid drops.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_a_result <= '0;
      o_b_result <= '0;
    end else if (r_state == S_EXECUTE) begin
      if (r_owner == OWNER_A) begin
        o_a_result <= i_alu_result;
      end else begin
        o_b_result <= i_alu_result;
      end
    end
  end

  // Valid flags: set with the result capture, cleared on the owner's ack.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_a_valid <= 1'b0;
      o_b_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_EXECUTE: begin
          if (r_owner == OWNER_A) o_a_valid <= 1'b1;
          else                    o_b_valid <= 1'b1;
        end
        S_RESPOND: begin
          if (w_owner_ack) begin
            if (r_owner == OWNER_A) o_a_valid <= 1'b0;
            else                    o_b_valid <= 1'b0;
          end
        end
        default: begin
          o_a_valid <= o_a_valid;
          o_b_valid <= o_b_valid;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_alu_arbiter.sv
// tb_cpu_alu_arbiter
// Table-driven cycle vectors against a round-robin instance, plus
// hand-written sequences for reset mid-operation and A/B contention
// (round-robin and fixed-priority instances side by side). Both instances
// share the requester inputs; each drives its own small ALU model.
module tb_cpu_alu_arbiter;

  localparam logic [5:0] OP_SIGNED_ADD = 6'd1;
  localparam logic [5:0] OP_AND        = 6'd3;
  localparam logic [5:0] OP_XOR        = 6'd4;
  localparam logic [5:0] OP_SHIFT_LEFT = 6'd8;

  typedef struct {
    logic        a_req;
    logic [5:0]  a_op;
    logic [31:0] a_op1;
    logic [31:0] a_op2;
    logic        a_ack;
    logic        b_req;
    logic [5:0]  b_op;
    logic [31:0] b_op1;
    logic [31:0] b_op2;
    logic        b_ack;
    logic        exp_a_ready;
    logic        exp_b_ready;
    logic        exp_a_valid;
    logic [31:0] exp_a_result;
    logic        exp_b_valid;
    logic [31:0] exp_b_result;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_ack, b_req, b_ack;
  logic [5:0]  a_op, b_op;
  logic [31:0] a_op1, a_op2, b_op1, b_op2;

  // Round-robin instance outputs
  logic        rr_a_ready, rr_a_valid, rr_b_ready, rr_b_valid;
  logic [31:0] rr_a_result, rr_b_result;
  logic [5:0]  rr_alu_op;
  logic [31:0] rr_alu_op1, rr_alu_op2, rr_alu_result;

  // Fixed-priority instance outputs
  logic        fp_a_ready, fp_a_valid, fp_b_ready, fp_b_valid;
  logic [31:0] fp_a_result, fp_b_result;
  logic [5:0]  fp_alu_op;
  logic [31:0] fp_alu_op1, fp_alu_op2, fp_alu_result;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vq[$];

  // Reference ALU standing in for CPU_ALU.
  function automatic logic [31:0] alu_ref(input logic [5:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    case (op)
      OP_SIGNED_ADD: return $unsigned($signed(x) + $signed(y));
      OP_AND:        return x & y;
      OP_XOR:        return x ^ y;
      OP_SHIFT_LEFT: return x << y[4:0];
      default:       return 32'h0;
    endcase
  endfunction

  assign rr_alu_result = alu_ref(rr_alu_op, rr_alu_op1, rr_alu_op2);
  assign fp_alu_result = alu_ref(fp_alu_op, fp_alu_op1, fp_alu_op2);

  cpu_alu_arbiter #(.P_ROUND_ROBIN(1'b1)) u_rr (
    .i_clock(clk), .i_reset(rst_n),
    .i_a_request(a_req), .i_a_op(a_op), .i_a_op1(a_op1), .i_a_op2(a_op2),
    .o_a_ready(rr_a_ready), .o_a_valid(rr_a_valid), .o_a_result(rr_a_result), .i_a_ack(a_ack),
    .i_b_request(b_req), .i_b_op(b_op), .i_b_op1(b_op1), .i_b_op2(b_op2),
    .o_b_ready(rr_b_ready), .o_b_valid(rr_b_valid), .o_b_result(rr_b_result), .i_b_ack(b_ack),
    .o_alu_op(rr_alu_op), .o_alu_op1(rr_alu_op1), .o_alu_op2(rr_alu_op2),
    .i_alu_result(rr_alu_result)
  );

  cpu_alu_arbiter #(.P_ROUND_ROBIN(1'b0)) u_fp (
    .i_clock(clk), .i_reset(rst_n),
    .i_a_request(a_req), .i_a_op(a_op), .i_a_op1(a_op1), .i_a_op2(a_op2),
    .o_a_ready(fp_a_ready), .o_a_valid(fp_a_valid), .o_a_result(fp_a_result), .i_a_ack(a_ack),
    .i_b_request(b_req), .i_b_op(b_op), .i_b_op1(b_op1), .i_b_op2(b_op2),
    .o_b_ready(fp_b_ready), .o_b_valid(fp_b_valid), .o_b_result(fp_b_result), .i_b_ack(b_ack),
    .o_alu_op(fp_alu_op), .o_alu_op1(fp_alu_op1), .o_alu_op2(fp_alu_op2),
    .i_alu_result(fp_alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_op = '0; a_op1 = '0; a_op2 = '0; a_ack = 1'b0;
    b_req = 1'b0; b_op = '0; b_op1 = '0; b_op2 = '0; b_ack = 1'b0;
  endtask

  function automatic vec_t v(input logic ar, input logic [5:0] ao, input logic [31:0] a1,
                             input logic [31:0] a2, input logic aa,
                             input logic br, input logic [5:0] bo, input logic [31:0] b1,
                             input logic [31:0] b2, input logic ba,
                             input logic xra, input logic xrb,
                             input logic xva, input logic [31:0] xresa,
                             input logic xvb, input logic [31:0] xresb);
    vec_t t;
    t.a_req = ar; t.a_op = ao; t.a_op1 = a1; t.a_op2 = a2; t.a_ack = aa;
    t.b_req = br; t.b_op = bo; t.b_op1 = b1; t.b_op2 = b2; t.b_ack = ba;
    t.exp_a_ready = xra; t.exp_b_ready = xrb;
    t.exp_a_valid = xva; t.exp_a_result = xresa;
    t.exp_b_valid = xvb; t.exp_b_result = xresb;
    return t;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " alu_op"},   {26'd0, rr_alu_op}, 32'h0);
    check({tag, " alu_op1"},  rr_alu_op1, 32'h0);
    check({tag, " alu_op2"},  rr_alu_op2, 32'h0);
    check({tag, " a_valid"},  {31'd0, rr_a_valid}, 32'h0);
    check({tag, " b_valid"},  {31'd0, rr_b_valid}, 32'h0);
    check({tag, " a_result"}, rr_a_result, 32'h0);
    check({tag, " b_result"}, rr_b_result, 32'h0);
  endtask

  initial begin
    // ---------------- vector table ----------------
    // A alone: 5 + (-2) = 3, ack in the third RESPOND cycle
    vq.push_back(v(1, OP_SIGNED_ADD, 32'd5, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'd0, 0, 32'd0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd3, 0, 32'd0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd3, 0, 32'd0));
    vq.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'd3, 0, 32'd0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd3, 0, 32'd0));
    // B shift 1 << 31, ack held low for 10 RESPOND cycles, A waits meanwhile
    vq.push_back(v(0, 0, 0, 0, 0, 1, OP_SHIFT_LEFT, 32'd1, 32'd31, 0, 0, 1, 0, 32'd3, 0, 32'd0));
    vq.push_back(v(1, OP_SIGNED_ADD, 32'd7, 32'd8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd3, 0, 32'd0));
    for (int k = 0; k < 10; k++) begin
      // k == 1 is a stray ack from A, which does not own the result
      vq.push_back(v(1, OP_SIGNED_ADD, 32'd7, 32'd8, (k == 1), 0, 0, 0, 0, 0,
                     0, 0, 0, 32'd3, 1, 32'h80000000));
    end
    vq.push_back(v(1, OP_SIGNED_ADD, 32'd7, 32'd8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'd3, 1, 32'h80000000));
    vq.push_back(v(1, OP_SIGNED_ADD, 32'd7, 32'd8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'd3, 0, 32'h80000000));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd3, 0, 32'h80000000));
    // A result 15 with ack already high on the first RESPOND cycle
    vq.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'd15, 0, 32'h80000000));
    // B xor
    vq.push_back(v(0, 0, 0, 0, 0, 1, OP_XOR, 32'hF0F0F0F0, 32'hFFFFFFFF, 0, 0, 1, 0, 32'd15, 0, 32'h80000000));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd15, 0, 32'h80000000));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'd15, 1, 32'h0F0F0F0F));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd15, 0, 32'h0F0F0F0F));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd15, 0, 32'h0F0F0F0F));

    // ---------------- reset state ----------------
    idle_inputs();
    rst_n = 1'b0;
    #23;
    check_all_zero("reset");
    check("reset a_ready", {31'd0, rr_a_ready}, 32'h0);
    check("reset b_ready", {31'd0, rr_b_ready}, 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      a_req = vq[i].a_req; a_op = vq[i].a_op; a_op1 = vq[i].a_op1; a_op2 = vq[i].a_op2; a_ack = vq[i].a_ack;
      b_req = vq[i].b_req; b_op = vq[i].b_op; b_op1 = vq[i].b_op1; b_op2 = vq[i].b_op2; b_ack = vq[i].b_ack;
      #4;
      check($sformatf("vec%0d a_ready", i),  {31'd0, rr_a_ready}, {31'd0, vq[i].exp_a_ready});
      check($sformatf("vec%0d b_ready", i),  {31'd0, rr_b_ready}, {31'd0, vq[i].exp_b_ready});
      check($sformatf("vec%0d a_valid", i),  {31'd0, rr_a_valid}, {31'd0, vq[i].exp_a_valid});
      check($sformatf("vec%0d a_result", i), rr_a_result, vq[i].exp_a_result);
      check($sformatf("vec%0d b_valid", i),  {31'd0, rr_b_valid}, {31'd0, vq[i].exp_b_valid});
      check($sformatf("vec%0d b_result", i), rr_b_result, vq[i].exp_b_result);
      next_cycle();
    end
    // ALU inputs keep the XOR operands through IDLE cycles with no requests
    check("hold alu_op",  {26'd0, rr_alu_op}, {26'd0, OP_XOR});
    check("hold alu_op1", rr_alu_op1, 32'hF0F0F0F0);
    check("hold alu_op2", rr_alu_op2, 32'hFFFFFFFF);

    // ---------------- reset mid-EXECUTE ----------------
    idle_inputs();
    a_req = 1'b1; a_op = OP_AND; a_op1 = 32'hFFFF0000; a_op2 = 32'h12345678;
    #4;
    check("rstmid grant a_ready", {31'd0, rr_a_ready}, 32'h1);
    next_cycle();
    a_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rstmid");
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      check($sformatf("rstmid post%0d a_valid", k), {31'd0, rr_a_valid}, 32'h0);
      check($sformatf("rstmid post%0d alu_op", k), {26'd0, rr_alu_op}, 32'h0);
      next_cycle();
    end
    // IDLE after reset: B is granted immediately, then acks on first RESPOND
    b_req = 1'b1; b_op = OP_AND; b_op1 = 32'hFFFF0000; b_op2 = 32'h12345678; b_ack = 1'b1;
    #4;
    check("rstmid idle b_ready", {31'd0, rr_b_ready}, 32'h1);
    next_cycle();
    b_req = 1'b0;
    #4;
    next_cycle();
    #4;
    check("rstmid b_valid", {31'd0, rr_b_valid}, 32'h1);
    check("rstmid b_result", rr_b_result, 32'h12340000);
    check("rstmid a_valid never", {31'd0, rr_a_valid}, 32'h0);
    next_cycle();

    // ---------------- contention, acks tied high ----------------
    // Last grant was B on both instances, so round-robin starts with A.
    a_req = 1'b1; a_op = OP_SIGNED_ADD; a_op1 = 32'd1; a_op2 = 32'd2; a_ack = 1'b1;
    b_req = 1'b1; b_op = OP_XOR;        b_op1 = 32'd3; b_op2 = 32'd5; b_ack = 1'b1;
    for (int c = 0; c < 12; c++) begin
      logic grant_cycle;
      logic rr_pick_b;
      grant_cycle = ((c % 3) == 0);
      rr_pick_b   = ((c / 3) % 2) == 1;
      #4;
      check($sformatf("rr c%0d a_ready", c), {31'd0, rr_a_ready}, {31'd0, grant_cycle && !rr_pick_b});
      check($sformatf("rr c%0d b_ready", c), {31'd0, rr_b_ready}, {31'd0, grant_cycle && rr_pick_b});
      check($sformatf("fp c%0d a_ready", c), {31'd0, fp_a_ready}, {31'd0, grant_cycle});
      check($sformatf("fp c%0d b_ready", c), {31'd0, fp_b_ready}, 32'h0);
      if (c == 2) begin
        check("rr c2 a_result", rr_a_result, 32'd3);
        check("fp c2 a_result", fp_a_result, 32'd3);
      end
      if (c == 5) begin
        check("rr c5 b_result", rr_b_result, 32'd6);
        check("fp c5 b_valid", {31'd0, fp_b_valid}, 32'h0);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
